// File: rtl/id_stage.sv
// Decode stage of the RV32I pipeline: register file with write-back bypass,
// main decoder, immediate generator and the ID/EX pipeline register.
// Every ex_* output is taken straight from a flop of the ID/EX register.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_ins_in,
  input  logic [XLEN-1:0] id_pc_plus_4,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc_plus_4,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jalr,
  output logic            ex_valid,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = id_ins_in[6:0];
  assign rd     = id_ins_in[11:7];
  assign funct3 = id_ins_in[14:12];
  assign rs1    = id_ins_in[19:15];
  assign rs2    = id_ins_in[24:20];
  assign funct7 = id_ins_in[31:25];

  // Register file; entry 0 is never written so x0 stays zero
  logic [XLEN-1:0] rf_q [NREGS];

  // Write-back port; runs independently of stall/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Combinational operand read with same-cycle write-back bypass
  logic [XLEN-1:0] rs1_data_d, rs2_data_d;
  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    if (rs1 != 5'd0) begin
      if (wb_we && (wb_rd == rs1)) rs1_data_d = wb_data;
      else                         rs1_data_d = rf_q[rs1];
    end
    if (rs2 != 5'd0) begin
      if (wb_we && (wb_rd == rs2)) rs2_data_d = wb_data;
      else                         rs2_data_d = rf_q[rs2];
    end
  end

  // Immediate formats, all sign-extended from instruction bit 31
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(XLEN-12){id_ins_in[31]}}, id_ins_in[31:20]};
  assign imm_s = {{(XLEN-12){id_ins_in[31]}}, id_ins_in[31:25], id_ins_in[11:7]};
  assign imm_b = {{(XLEN-12){id_ins_in[31]}}, id_ins_in[7], id_ins_in[30:25],
                  id_ins_in[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){id_ins_in[31]}}, id_ins_in[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){id_ins_in[31]}}, id_ins_in[19:12], id_ins_in[20],
                  id_ins_in[30:21], 1'b0};

  // Main decoder: controls, ALU op and immediate selection
  logic [XLEN-1:0] imm_d;
  logic [3:0]      alu_op_d;
  logic            alu_src_d, mem_read_d, mem_write_d, reg_write_d;
  logic            branch_d, jump_d, jalr_d, illegal_d;
  always_comb begin
    imm_d       = '0;
    alu_op_d    = ALU_ADD;
    alu_src_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    jalr_d      = 1'b0;
    illegal_d   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        case (funct3)
          3'b000:  alu_op_d = (funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_d = ALU_SLL;
          3'b010:  alu_op_d = ALU_SLT;
          3'b011:  alu_op_d = ALU_SLTU;
          3'b100:  alu_op_d = ALU_XOR;
          3'b101:  alu_op_d = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_d = ALU_OR;
          default: alu_op_d = ALU_AND;
        endcase
        // funct7=0x20 only has a meaning for SUB and SRA
        if ((funct7 != 7'h00) && (funct7 != 7'h20)) illegal_d = 1'b1;
        if ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101))
          illegal_d = 1'b1;
      end
      OP_I: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        imm_d       = imm_i;
        case (funct3)
          3'b000:  alu_op_d = ALU_ADD;
          3'b001: begin
            alu_op_d = ALU_SLL;
            if (funct7 != 7'h00) illegal_d = 1'b1;
          end
          3'b010:  alu_op_d = ALU_SLT;
          3'b011:  alu_op_d = ALU_SLTU;
          3'b100:  alu_op_d = ALU_XOR;
          3'b101: begin
            alu_op_d = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            if ((funct7 != 7'h00) && (funct7 != 7'h20)) illegal_d = 1'b1;
          end
          3'b110:  alu_op_d = ALU_OR;
          default: alu_op_d = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        mem_read_d  = 1'b1;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        imm_d       = imm_i;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_s;
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        alu_op_d = ALU_SUB;
        imm_d    = imm_b;
      end
      OP_JAL: begin
        jump_d      = 1'b1;
        reg_write_d = 1'b1;
        imm_d       = imm_j;
      end
      OP_JALR: begin
        jump_d      = 1'b1;
        jalr_d      = 1'b1;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        imm_d       = imm_i;
      end
      OP_LUI: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALU_PASSB;
        imm_d       = imm_u;
      end
      OP_AUIPC: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        imm_d       = imm_u;
      end
      default: illegal_d = 1'b1;
    endcase
    // An illegal encoding must never produce side effects downstream
    if (illegal_d) begin
      alu_op_d    = ALU_ADD;
      alu_src_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
      jalr_d      = 1'b0;
    end
  end

  // ID/EX register state
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_plus_4_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  logic [3:0]      alu_op_q;
  logic            alu_src_q, mem_read_q, mem_write_q, reg_write_q;
  logic            branch_q, jump_q, jalr_q, valid_q, illegal_q;

  // ID/EX register: flush loads a bubble (wins over stall), stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_plus_4_q <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      jalr_q      <= 1'b0;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!stall) begin
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_plus_4_q <= id_pc_plus_4;
      rs1_q       <= rs1;
      rs2_q       <= rs2;
      rd_q        <= rd;
      funct3_q    <= funct3;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      jalr_q      <= jalr_d;
      valid_q     <= 1'b1;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_pc_plus_4 = pc_plus_4_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_funct3    = funct3_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_alu_src   = alu_src_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_reg_write = reg_write_q;
  assign ex_branch    = branch_q;
  assign ex_jump      = jump_q;
  assign ex_jalr      = jalr_q;
  assign ex_valid     = valid_q;
  assign ex_illegal   = illegal_q;

endmodule
